// File: rtl/hpf_mult_scheduler_if.sv
// Request/multiplier/result bundle between the HPF channel requesters and the shared-multiplier scheduler.
interface hpf_mult_scheduler_if #(
    parameter int N_REQ = 4
);
    logic                   enable;
    logic [N_REQ-1:0]       req;
    logic [16*N_REQ-1:0]    req_in;
    logic [16*N_REQ-1:0]    req_coef;
    logic [N_REQ-1:0]       grant;
    logic [17:0]            mult_a;
    logic [17:0]            mult_b;
    logic [35:0]            mult_p;
    logic                   res_valid;
    logic [2:0]             res_id;
    logic [31:0]            res_data;
    logic                   busy;

    modport master (
        output enable, req, req_in, req_coef, mult_p,
        input  grant, mult_a, mult_b, res_valid, res_id, res_data, busy
    );

    modport slave (
        input  enable, req, req_in, req_coef, mult_p,
        output grant, mult_a, mult_b, res_valid, res_id, res_data, busy
    );
endinterface

// File: rtl/hpf_mult_scheduler.sv
// Round-robin arbiter feeding one pipelined 18x18 multiplier from N_REQ HPF channels,
// with a tag pipeline that routes each product back to its requester in grant order.
module hpf_mult_scheduler #(
    parameter int N_REQ        = 4,
    parameter int MULT_LATENCY = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    hpf_mult_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                         r_state;
    logic [N_REQ-1:0]               r_grant;
    logic [2:0]                     r_gid;
    logic [2:0]                     r_ptr;
    logic [17:0]                    r_mult_a;
    logic [17:0]                    r_mult_b;
    logic [MULT_LATENCY-1:0]        r_vld_pipe;
    logic [MULT_LATENCY-1:0][2:0]   r_id_pipe;
    logic                           r_res_valid;
    logic [2:0]                     r_res_id;
    logic [31:0]                    r_res_data;

    logic [7:0]                     w_elig;
    logic                           w_found;
    logic [2:0]                     w_sel;
    logic [N_REQ-1:0]               w_onehot;
    logic                           w_go;
    logic                           w_inflight;
    logic [15:0]                    w_in;
    logic [15:0]                    w_coef;
    logic                           w_unused_p;

    // The requester granted last edge is masked so it can drop req or update operands safely.
    always_comb begin
        w_elig = '0;
        w_elig[N_REQ-1:0] = bus.req & ~r_grant;
    end

    always_comb begin
        logic [2:0] idx;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = 3'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_REQ; i++)
            w_onehot[i] = (w_sel == 3'(i));
    end

    assign w_go       = (r_state == RUN) && bus.enable && w_found;
    assign w_inflight = (|r_grant) || (|r_vld_pipe);
    assign w_in       = bus.req_in[16*w_sel +: 16];
    assign w_coef     = bus.req_coef[16*w_sel +: 16];

    // Product bits outside [34:3] are sign copies or scaling zeros for 16x16 operands.
    assign w_unused_p = ^{bus.mult_p[35], bus.mult_p[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_gid       <= '0;
            r_ptr       <= 3'(N_REQ-1);
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_vld_pipe  <= '0;
            r_id_pipe   <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                IDLE:    if (bus.enable) r_state <= RUN;
                RUN:     if (!bus.enable) r_state <= w_inflight ? DRAIN : IDLE;
                DRAIN:   if (bus.enable) r_state <= RUN;
                         else if (!w_inflight) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            r_grant <= w_go ? w_onehot : '0;
            if (w_go) begin
                r_gid    <= w_sel;
                r_ptr    <= w_sel;
                r_mult_a <= {w_in, 2'b00};
                r_mult_b <= {w_coef[15], w_coef, 1'b0};
            end

            // Tag enters when the multiplier samples the operands, one edge after the grant.
            r_vld_pipe[0] <= |r_grant;
            r_id_pipe[0]  <= r_gid;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_id_pipe[i]  <= r_id_pipe[i-1];
            end

            r_res_valid <= r_vld_pipe[MULT_LATENCY-1];
            if (r_vld_pipe[MULT_LATENCY-1]) begin
                r_res_id   <= r_id_pipe[MULT_LATENCY-1];
                r_res_data <= bus.mult_p[34:3];
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.mult_a    = r_mult_a;
    assign bus.mult_b    = r_mult_b;
    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_res_id;
    assign bus.res_data  = r_res_data;
    assign bus.busy      = (r_state != IDLE) || (|r_vld_pipe) || r_res_valid;
endmodule

// File: tb/tb_hpf_mult_scheduler.sv
// Directed bench for hpf_mult_scheduler: behavioural multiplier plus a grant-order scoreboard.
module tb_hpf_mult_scheduler;
    localparam int N  = 4;
    localparam int ML = 3;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc_cnt = 0;
    int   res_cnt = 0;
    int   last;
    int   n0;
    exp_t q[$];

    logic [16*N-1:0]    snap_in;
    logic [16*N-1:0]    snap_coef;
    logic signed [35:0] w_prod;
    logic signed [35:0] p_pipe [ML] = '{default: '0};

    hpf_mult_scheduler_if #(.N_REQ(N)) bus ();

    hpf_mult_scheduler #(.N_REQ(N), .MULT_LATENCY(ML)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Multiplier model: product of operands sampled at an edge appears ML edges later.
    assign w_prod = $signed(bus.mult_a) * $signed(bus.mult_b);
    always @(posedge clk) begin
        p_pipe[0] <= w_prod;
        for (int i = 1; i < ML; i++) p_pipe[i] <= p_pipe[i-1];
    end
    assign bus.mult_p = p_pipe[ML-1];

    always @(posedge clk) begin
        cyc_cnt   <= cyc_cnt + 1;
        snap_in   <= bus.req_in;
        snap_coef <= bus.req_coef;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            if (bus.res_valid) begin
                if (q.size() == 0) begin
                    chk("res_spurious", 64'(bus.res_valid), 64'(q.size() != 0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    res_cnt++;
                    chk("res_id", 64'(bus.res_id), 64'(e.id));
                    chk("res_data", 64'(bus.res_data), 64'(e.data));
                    chk("res_latency", 64'(cyc_cnt - e.cyc), 64'(ML + 1));
                end
            end
            if (bus.grant != '0) begin
                chk("grant_onehot", 64'($countones(bus.grant)), 64'd1);
                for (int i = 0; i < N; i++) begin
                    if (bus.grant[i]) begin
                        shortint a;
                        shortint c;
                        exp_t    e;
                        a = shortint'(snap_in[16*i +: 16]);
                        c = shortint'(snap_coef[16*i +: 16]);
                        e.id   = 3'(i);
                        e.data = 32'(int'(a) * int'(c));
                        e.cyc  = cyc_cnt;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int c);
        bus.req_in[16*i +: 16]   = 16'(a);
        bus.req_coef[16*i +: 16] = 16'(c);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && !bus.res_valid) break;
            nxt();
        end
        chk("drain_done", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable   = 1'b0;
        bus.req      = '0;
        bus.req_in   = '0;
        bus.req_coef = '0;
        repeat (2) nxt();
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_mult_a", 64'(bus.mult_a), 64'd0);
        chk("rst_mult_b", 64'(bus.mult_b), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_id", 64'(bus.res_id), 64'd0);
        chk("rst_res_data", 64'(bus.res_data), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        // single op: requester 0 wins first after reset
        reset_n    = 1'b1;
        bus.enable = 1'b1;
        nxt();
        set_op(0, 10, -10);
        bus.req = 4'b0001;
        nxt();
        chk("single_grant", 64'(bus.grant), 64'd1);
        chk("single_mult_a", 64'(bus.mult_a), 64'd40);
        chk("single_mult_b", 64'(bus.mult_b), 64'h3FFEC);
        bus.req = '0;
        nxt();
        chk("single_pulse", 64'(bus.grant), 64'd0);
        wait_drain();
        chk("single_res_data", 64'(bus.res_data), 64'hFFFFFF9C);
        last = 0;

        // all requesters held: one grant per cycle in rotation
        for (int i = 0; i < N; i++) set_op(i, 100 * (i + 1) - 7, -(i * 37) + 11);
        bus.req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            nxt();
            last = (last + 1) % N;
            chk("rr_all", 64'(bus.grant), 64'(1 << last));
        end
        bus.req = '0;
        wait_drain();

        // lone requester: alternate cycles only
        set_op(2, -1234, 567);
        bus.req = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            nxt();
            chk("rr_single", 64'(bus.grant), (k % 2 == 0) ? 64'd4 : 64'd0);
        end
        last = 2;
        bus.req = '0;
        wait_drain();

        // operand extremes
        set_op(0, -32768, -32768);
        set_op(1, 32767, -32768);
        bus.req = 4'b0011;
        nxt();
        chk("ext_grant0", 64'(bus.grant), 64'd1);
        nxt();
        chk("ext_grant1", 64'(bus.grant), 64'd2);
        bus.req = '0;
        wait_drain();
        chk("ext_last_data", 64'(bus.res_data), 64'hC0008000);
        last = 1;

        // enable dropped after three grants; req stays high through the drain
        n0 = res_cnt;
        for (int i = 0; i < N; i++) set_op(i, 3 * i - 50, 2 * i + 9);
        bus.req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            nxt();
            last = (last + 1) % N;
            chk("drop_grant", 64'(bus.grant), 64'(1 << last));
        end
        bus.enable = 1'b0;
        nxt();
        chk("drop_nogrant", 64'(bus.grant), 64'd0);
        chk("drop_busy", 64'(bus.busy), 64'd1);
        for (int k = 0; k < 8; k++) begin
            nxt();
            chk("drain_nogrant", 64'(bus.grant), 64'd0);
        end
        chk("drain_count", 64'(res_cnt - n0), 64'd3);
        chk("drain_idle", 64'(bus.busy), 64'd0);
        bus.req = '0;

        // reset one cycle after a grant discards the op
        bus.enable = 1'b1;
        nxt();
        set_op(0, 5, 7);
        bus.req = 4'b0001;
        nxt();
        chk("mid_grant", 64'(bus.grant), 64'd1);
        bus.req = '0;
        nxt();
        n0 = res_cnt;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", 64'(bus.grant), 64'd0);
        chk("mid_rst_mult_a", 64'(bus.mult_a), 64'd0);
        chk("mid_rst_mult_b", 64'(bus.mult_b), 64'd0);
        chk("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("mid_rst_res_data", 64'(bus.res_data), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        nxt();
        reset_n = 1'b1;
        repeat (10) nxt();
        chk("mid_no_result", 64'(res_cnt - n0), 64'd0);
        chk("mid_res_valid", 64'(bus.res_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hpf_mult_scheduler.md
HPF_MULT_SCHEDULER -- requirements
Module: hpf_mult_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of filter-channel requesters sharing one multiplier_18x18 (2..8).
REQ-002 Parameter MULT_LATENCY, default 3: clock cycles from mult_a/mult_b sampled to the matching mult_p valid.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high allows new grants; low stops grants and drains operations in flight.
REQ-006 req  input  N_REQ  per-requester request; held high with stable operands until granted.
REQ-007 req_in  input  16*N_REQ  signed multiplier_in per requester; slice i is [16i+15:16i].
REQ-008 req_coef  input  16*N_REQ  signed HPF coefficient per requester, same slicing.
REQ-009 grant  output  N_REQ  registered one-hot pulse, one cycle: operands of that requester were captured.
REQ-010 mult_a  output  18  registered operand A to the multiplier.
REQ-011 mult_b  output  18  registered operand B to the multiplier.
REQ-012 mult_p  input  36  multiplier product.
REQ-013 res_valid  output  1  one-cycle pulse: res_data/res_id valid.
REQ-014 res_id  output  3  index of the requester owning res_data.
REQ-015 res_data  output  32  signed product multiplier_in*coefficient.
REQ-016 busy  output  1  high while any operation is in flight or state is not IDLE.

Function
REQ-017 State machine: IDLE (no req or enable low, pipeline empty), RUN (enable high), DRAIN (enable low, ops in flight); IDLE->RUN when enable high; RUN->DRAIN when enable falls with ops in flight, else RUN->IDLE; DRAIN->IDLE when the in-flight count reaches 0; DRAIN->RUN when enable rises.
REQ-018 In RUN, each edge with at least one eligible req grants exactly one requester, round-robin, searching from the index after the last granted one (initial pointer after reset = N_REQ-1, so requester 0 wins first).
REQ-019 A requester granted at edge t is ineligible at edge t+1; this makes stale re-grant impossible while the requester drops req or updates its operands after seeing grant.
REQ-020 On grant of requester i: mult_a <= {req_in[i], 2'b00}; mult_b <= {req_coef[i][15], req_coef[i], 1'b0}; grant[i] <= 1 for one cycle.
REQ-021 When no grant occurs, mult_a and mult_b hold their previous values and grant = 0.
REQ-022 Tag pipeline: a valid bit plus 3-bit id are shifted MULT_LATENCY stages in lockstep with the multiplier.
REQ-023 res_data <= mult_p[34:3] and res_id <= the tag id, registered one edge after the tag exits, so grant-to-res_valid latency is MULT_LATENCY+1 edges.
REQ-024 Results return in grant order; there is one result per grant and none are dropped or duplicated; throughput is 1 result/cycle with at least 2 active requesters and 1 per 2 cycles with a single requester.
REQ-025 mult_p[35:34] are sign copies for all 16x16 inputs; no saturation logic.
REQ-026 In DRAIN and IDLE, grant stays 0 while in-flight results still emerge with res_valid.
REQ-027 busy = (state != IDLE) or any tag-pipeline valid bit or res_valid.
REQ-028 req bits with index >= N_REQ do not exist; res_id upper bits are 0 when N_REQ <= 4.

Reset
REQ-029 reset_n low immediately clears grant, mult_a, mult_b, res_valid, res_id, res_data, busy, and all tag valid bits to 0, sets state to IDLE and sets the round-robin pointer to N_REQ-1.
REQ-030 Reset asserted mid-operation discards every in-flight result; after release, no res_valid occurs until a new grant has aged MULT_LATENCY+1 edges.

Verification
REQ-031 Single op: req[0]=1, req_in=10, coef=-10 -> grant[0] pulse; mult_a=40; mult_b=18'h3FFEC; MULT_LATENCY+1 edges later res_valid=1, res_id=0, res_data=32'hFFFFFF9C (-100).
REQ-032 All 4 req held high continuously -> grants 0,1,2,3,0,... one per cycle; res_id follows the same order; no gaps after the pipeline fills.
REQ-033 Only req[2] held high -> grant[2] on alternate cycles; every other cycle has no grant.
REQ-034 Extremes: in=-32768, coef=-32768 -> res_data=32'h40000000; in=32767, coef=-32768 -> res_data=32'hC0008000.
REQ-035 enable dropped the cycle after 3 grants -> state DRAIN, no further grants, exactly 3 res_valid pulses, then busy=0 and state IDLE.
REQ-036 reset_n pulsed low 1 cycle after a grant -> all outputs 0 immediately; no res_valid appears for the discarded op.
